cart_mapper_gen: RTL and testbench
==================================

# cart_mapper_gen

Parametrised bank-switching mapper for MSX ROM cartridges: one engine replaces the per-mapper address blocks. It decodes CPU bank-register writes for no-mapper, Konami, Konami-SCC, ASCII8 and ASCII16 carts, and forms the masked backing-memory address. It drives a registered request/ready handshake toward SDRAM/BRAM and stretches the CPU cycle with `wait_n`. It sits between the slot decode (`SLTSL_n`) and the cart memory, fed by `rom_detect` outputs (`mapper`, `offset`, `rom_size`).

## Interface
- `ADDR_WIDTH`, 25: backing-memory address width.
- `BANK_BITS`, 8: width of each bank register.
- `SRAM_AW`, 13: SRAM address width (only used with `CART_MAPPER_SRAM_EN`).
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `mapper` in 3: mapper code. 1 = nomapper, 3 = Konami, 4 = Konami SCC, 5 = ASCII8, 6 = ASCII16. Codes 0, 2 and 7 are treated as nomapper.
- `offset` in 4: nomapper base, in 4 KB units.
- `rom_size` in ADDR_WIDTH: ROM size in bytes; always a power of two.
- `addr` in 16: CPU address.
- `d_from_cpu` in 8: CPU write data.
- `wr`, `rd` in 1: CPU strobes, active-high, multi-cycle.
- `SLTSL_n` in 1: slot select, active-low.
- `mem_addr` out ADDR_WIDTH: registered memory address.
- `mem_rd` out 1: read request, level.
- `mem_we` out 1: SRAM write request, level.
- `mem_sram` out 1: 1 means the access targets SRAM, not ROM.
- `mem_ready` in 1: memory done, 1-cycle pulse.
- `wait_n` out 1: CPU wait, active-low.

## Operation
- **Bank registers.** `bank[0..3]`, BANK_BITS wide each, map to 8 KB windows 4000h, 6000h, 8000h and A000h. The window index is `addr[15:13]-2`.
- **Reset defaults and mode change.** On reset, and on the cycle after any change of `mapper`, the banks load their mode defaults:
  - Konami and SCC: 0, 1, 2, 3.
  - ASCII8 and ASCII16: 0, 0, 0, 0.
  - All SRAM-select flags are cleared.
- **Write decode.** Decode happens on the first cycle of `wr` while `SLTSL_n`=0 (edge-detected, one update per strobe). The register takes `d_from_cpu[BANK_BITS-1:0]`.
  - Konami: 6000–7FFF → bank1; 8000–9FFF → bank2; A000–BFFF → bank3. Bank0 is fixed at 0.
  - SCC: 5000–57FF → bank0; 7000–77FF → bank1; 9000–97FF → bank2; B000–B7FF → bank3.
  - ASCII8: 6000–67FF → bank0; 6800–6FFF → bank1; 7000–77FF → bank2; 7800–7FFF → bank3.
  - ASCII16: 6000–67FF writes bank0 and bank1 as {v,0} and {v,1}. 7000–77FF writes bank2 and bank3 the same way.
- **Address.** For mapped modes: `({bank[w], addr[12:0]}) & (rom_size-1)`, zero-extended to ADDR_WIDTH.
- **Nomapper address.** `(addr - {offset,12'h000}) & (rom_size-1)`. Every slot-selected address is valid.
- **Out-of-range accesses.** In mapped modes, reads outside 4000–BFFF issue no request. They complete immediately with `wait_n`=1.
- **Access state machine.**
  - IDLE: on the first cycle of `rd`, with `SLTSL_n`=0 and a valid address, latch `mem_addr` and go to REQ. `wait_n` drops combinationally in that same cycle.
  - REQ: `mem_rd`=1 (or `mem_we`=1 for an SRAM write). `wait_n`=0. Go to DONE on `mem_ready`.
  - DONE: `mem_rd`/`mem_we`=0 and `wait_n`=1. Stay until `rd` and `wr` are both low, then go to IDLE.
- **Simultaneous `rd` and `wr`.** `wr` wins and `rd` is ignored for that strobe.
- **Bank write during REQ.** The register updates, but the latched `mem_addr` is unchanged.

## Timing
- **Reset values:** state IDLE, `mem_addr`=0, `mem_rd`=0, `mem_we`=0, `mem_sram`=0, `wait_n`=1, banks at the defaults above.
- **Request latency:** `rd` edge in cycle N → `mem_rd`=1 and `mem_addr` valid from cycle N+1.
- **Completion:** `mem_ready` in cycle M → `mem_rd`=0 and `wait_n`=1 in cycle M+1.
- **Ready at the earliest point:** `mem_ready` in cycle N+1 is accepted. Minimum stretch is 1 cycle.
- **Bank update:** a bank write is visible to a read that starts on the next cycle.
- **Reset mid-access:** `reset_n` low aborts at once. Outputs go to reset values asynchronously, and any `mem_ready` that arrives later is ignored.

## Configuration
- **Macro:** `CART_MAPPER_SRAM_EN`.
- **Defined:** ASCII8/16 bank writes with `d_from_cpu[7]`=1 set that window's SRAM flag and clear it otherwise.
  - Reads of a flagged window at 8000–BFFF: `mem_sram`=1, `mem_addr = {bank[SRAM_AW-14:0], addr[12:0]}` masked to SRAM_AW bits.
  - Writes to a flagged window at 8000–BFFF: a `mem_we` request through REQ/DONE.
  - In this mode BANK_BITS is limited to 7.
- **Undefined:** `mem_sram` and `mem_we` are tied 0, there are no flags, and bit 7 is an ordinary bank bit.

## Test plan
- **Reset:** assert `reset_n`=0 mid-REQ → `mem_rd`=0 and `wait_n`=1 with no clock edge. SCC banks read back as 0, 1, 2, 3.
- **Konami SCC:** `rom_size`=128 KB, write 0Fh to 9000h, then read 8123h → `mem_addr`=01E123h (0Fh·2000h+0123h).
- **ASCII16:** write 05h to 7000h, then read A010h → `mem_addr`=16010h.
- **Nomapper:** `offset`=4, `rom_size`=32 KB, read 4001h → `mem_addr`=0001h, `mem_rd` in N+1.
- **Handshake:** `mem_ready` delayed 5 cycles → `wait_n` low exactly from rd-edge cycle N until `mem_ready`; one `mem_rd` level, no re-request while `rd` stays high.
- **SRAM (macro on):** ASCII8 write 80h to 7000h, write 5Ah to 8004h → `mem_sram`=1, `mem_we`=1, `mem_addr`=0004h. Write 03h to 7000h → next read of 8004h has `mem_sram`=0.

Source files
------------

// File: rtl/cart_mapper_gen.sv
// MSX ROM cartridge bank mapper (nomapper/Konami/SCC/ASCII8/ASCII16) with a registered
// request/ready handshake. Define CART_MAPPER_SRAM_EN to enable ASCII8/16 SRAM windows.
module cart_mapper_gen #(
  parameter int ADDR_WIDTH = 25,
  parameter int BANK_BITS  = 8,
  parameter int SRAM_AW    = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            mapper,
  input  logic [3:0]            offset,
  input  logic [ADDR_WIDTH-1:0] rom_size,
  input  logic [15:0]           addr,
  input  logic [7:0]            d_from_cpu,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  SLTSL_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_we,
  output logic                  mem_sram,
  input  logic                  mem_ready,
  output logic                  wait_n
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] MAP_NONE    = 3'd1;
  localparam logic [2:0] MAP_KONAMI  = 3'd3;
  localparam logic [2:0] MAP_SCC     = 3'd4;
  localparam logic [2:0] MAP_ASCII8  = 3'd5;
  localparam logic [2:0] MAP_ASCII16 = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] SRAM_MASK = ADDR_WIDTH'((64'd1 << SRAM_AW) - 64'd1);

  logic [1:0]            state;
  logic [2:0]            mode;
  logic [2:0]            mapper_q;
  logic                  init_q;
  logic                  rd_q, wr_q, rd_rise, wr_rise;
  logic [BANK_BITS-1:0]  bank    [4];
  logic [BANK_BITS-1:0]  bank_nv [4];
  logic [3:0]            bank_we;
  logic [7:0]            dv;
  logic [BANK_BITS-1:0]  wv, wv_even, wv_odd;
  logic [1:0]            win;
  logic                  in_window, addr_valid, sram_hit;
  logic                  start_rd, start_wr, start;
  logic [15:0]           nom_diff;
  logic [ADDR_WIDTH-1:0] rom_mask, map_full, next_addr;
`ifdef CART_MAPPER_SRAM_EN
  logic [3:0]            sram_flag;
`endif

  always_comb begin
    case (mapper)
      MAP_KONAMI, MAP_SCC, MAP_ASCII8, MAP_ASCII16: mode = mapper;
      default:                                      mode = MAP_NONE;
    endcase
  end

  assign rd_rise = rd & ~rd_q;
  assign wr_rise = wr & ~wr_q;

  // Bank register write decode
  always_comb begin
`ifdef CART_MAPPER_SRAM_EN
    dv = {1'b0, d_from_cpu[6:0]};
`else
    dv = d_from_cpu;
`endif
    wv      = dv[BANK_BITS-1:0];
    wv_even = {dv[BANK_BITS-2:0], 1'b0};
    wv_odd  = {dv[BANK_BITS-2:0], 1'b1};
    bank_we = '0;
    for (int unsigned i = 0; i < 4; i++) bank_nv[i] = wv;
    if (wr_rise && !SLTSL_n) begin
      case (mode)
        MAP_KONAMI: begin
          case (addr[15:13])
            3'd3: bank_we[1] = 1'b1;
            3'd4: bank_we[2] = 1'b1;
            3'd5: bank_we[3] = 1'b1;
            default: ;
          endcase
        end
        MAP_SCC: begin
          case (addr[15:11])
            5'b01010: bank_we[0] = 1'b1;
            5'b01110: bank_we[1] = 1'b1;
            5'b10010: bank_we[2] = 1'b1;
            5'b10110: bank_we[3] = 1'b1;
            default: ;
          endcase
        end
        MAP_ASCII8: begin
          if (addr[15:13] == 3'b011) bank_we[addr[12:11]] = 1'b1;
        end
        MAP_ASCII16: begin
          // A 16 KB page is two consecutive 8 KB windows
          bank_nv[0] = wv_even;
          bank_nv[1] = wv_odd;
          bank_nv[2] = wv_even;
          bank_nv[3] = wv_odd;
          if (addr[15:11] == 5'b01100) bank_we[1:0] = 2'b11;
          if (addr[15:11] == 5'b01110) bank_we[3:2] = 2'b11;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    win        = addr[14:13] - 2'd2;
    in_window  = (addr[15:14] == 2'b01) || (addr[15:14] == 2'b10);
    addr_valid = (mode == MAP_NONE) || in_window;
    rom_mask   = rom_size - ADDR_WIDTH'(1);
    nom_diff   = addr - {offset, 12'h000};
    map_full   = ADDR_WIDTH'({bank[win], addr[12:0]});
    sram_hit   = 1'b0;
`ifdef CART_MAPPER_SRAM_EN
    sram_hit   = ((mode == MAP_ASCII8) || (mode == MAP_ASCII16)) &&
                 (addr[15:14] == 2'b10) && sram_flag[win];
`endif
    if (sram_hit)               next_addr = map_full & SRAM_MASK;
    else if (mode == MAP_NONE)  next_addr = ADDR_WIDTH'(nom_diff) & rom_mask;
    else                        next_addr = map_full & rom_mask;
  end

  assign start_rd = rd_rise && !wr && !SLTSL_n && addr_valid;
  assign start_wr = wr_rise && !SLTSL_n && sram_hit;
  assign start    = (state == ST_IDLE) && (start_rd || start_wr);
  assign wait_n   = !((state == ST_REQ) || start);

  // Strobe history resets high so a strobe held across reset is not a new edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mapper_q <= '0;
      init_q   <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) bank[i] <= BANK_BITS'(i);
`ifdef CART_MAPPER_SRAM_EN
      sram_flag <= '0;
`endif
    end else begin
      mapper_q <= mapper;
      init_q   <= 1'b0;
      rd_q     <= rd;
      wr_q     <= wr;
      if (init_q || (mapper != mapper_q)) begin
        for (int unsigned i = 0; i < 4; i++)
          bank[i] <= ((mode == MAP_KONAMI) || (mode == MAP_SCC)) ? BANK_BITS'(i) : '0;
`ifdef CART_MAPPER_SRAM_EN
        sram_flag <= '0;
`endif
      end else begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (bank_we[i]) begin
            bank[i] <= bank_nv[i];
`ifdef CART_MAPPER_SRAM_EN
            if ((mode == MAP_ASCII8) || (mode == MAP_ASCII16)) sram_flag[i] <= d_from_cpu[7];
`endif
          end
        end
      end
    end
  end

`ifndef CART_MAPPER_SRAM_EN
  assign mem_we   = 1'b0;
  assign mem_sram = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
`ifdef CART_MAPPER_SRAM_EN
      mem_we   <= 1'b0;
      mem_sram <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_REQ;
            mem_addr <= next_addr;
            mem_rd   <= start_rd;
`ifdef CART_MAPPER_SRAM_EN
            mem_we   <= start_wr;
            mem_sram <= sram_hit;
`endif
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            state  <= ST_DONE;
            mem_rd <= 1'b0;
`ifdef CART_MAPPER_SRAM_EN
            mem_we <= 1'b0;
`endif
          end
        end
        ST_DONE: begin
          if (!rd && !wr) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_mapper_gen.sv
// Self-checking bench for cart_mapper_gen: directed cases plus randomized accesses
// checked against an arithmetic model of the bank registers and address rules.
module tb_cart_mapper_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  mapper;
  logic [3:0]  offset;
  logic [24:0] rom_size;
  logic [15:0] addr;
  logic [7:0]  d_from_cpu;
  logic        wr, rd, SLTSL_n, mem_ready;
  logic [24:0] mem_addr;
  logic        mem_rd, mem_we, mem_sram, wait_n;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned mb[4];

  always #5 clk = ~clk;

  cart_mapper_gen #(.ADDR_WIDTH(25), .BANK_BITS(8), .SRAM_AW(13)) dut (
    .clk(clk), .reset_n(reset_n), .mapper(mapper), .offset(offset),
    .rom_size(rom_size), .addr(addr), .d_from_cpu(d_from_cpu), .wr(wr), .rd(rd),
    .SLTSL_n(SLTSL_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_sram(mem_sram), .mem_ready(mem_ready), .wait_n(wait_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned kind(input int unsigned m);
    return (m >= 3 && m <= 6) ? m : 1;
  endfunction

  task automatic model_defaults();
    int unsigned k = kind(mapper);
    for (int i = 0; i < 4; i++) mb[i] = (k == 3 || k == 4) ? i : 0;
  endtask

  task automatic model_write(input int unsigned a, input int unsigned d);
    int unsigned k = kind(mapper);
    int unsigned v = d & 'hFF;
`ifdef CART_MAPPER_SRAM_EN
    v = v & 'h7F;
`endif
    if (k == 3) begin
      if (a >= 'h6000 && a < 'h8000) mb[1] = v;
      else if (a >= 'h8000 && a < 'hA000) mb[2] = v;
      else if (a >= 'hA000 && a < 'hC000) mb[3] = v;
    end else if (k == 4) begin
      if (a >= 'h5000 && a < 'h5800) mb[0] = v;
      else if (a >= 'h7000 && a < 'h7800) mb[1] = v;
      else if (a >= 'h9000 && a < 'h9800) mb[2] = v;
      else if (a >= 'hB000 && a < 'hB800) mb[3] = v;
    end else if (k == 5) begin
      if (a >= 'h6000 && a < 'h8000) mb[(a - 'h6000) / 'h800] = v;
    end else if (k == 6) begin
      if (a >= 'h6000 && a < 'h6800) begin
        mb[0] = (2 * v) % 256; mb[1] = (2 * v + 1) % 256;
      end else if (a >= 'h7000 && a < 'h7800) begin
        mb[2] = (2 * v) % 256; mb[3] = (2 * v + 1) % 256;
      end
    end
  endtask

  function automatic int unsigned exp_addr(input int unsigned a);
    if (kind(mapper) == 1)
      return ((a + 'h10000 - offset * 4096) % 'h10000) % rom_size;
    return (mb[a / 8192 - 2] * 8192 + a % 8192) % rom_size;
  endfunction

  function automatic bit is_valid(input int unsigned a);
    return (kind(mapper) == 1) || (a >= 'h4000 && a < 'hC000);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mapper(input int unsigned m);
    if (m != mapper) begin
      mapper = 3'(m);
      cyc();
      cyc();
      model_defaults();
    end
  endtask

  task automatic do_write(input int unsigned a, input int unsigned d);
    addr = 16'(a); d_from_cpu = 8'(d); SLTSL_n = 1'b0; wr = 1'b1;
    cyc();
    wr = 1'b0;
    cyc();
    SLTSL_n = 1'b1;
    model_write(a, d);
  endtask

  task automatic do_read(input int unsigned a, input int unsigned delay, input int unsigned hold);
    bit          v = is_valid(a);
    int unsigned e = exp_addr(a);
    addr = 16'(a); SLTSL_n = 1'b0; rd = 1'b1;
    #1;
    chk("wait_n_at_edge", wait_n, v ? 0 : 1);
    cyc();
    chk("mem_rd_latency", mem_rd, v);
    chk("mem_sram_rd", mem_sram, 0);
    chk("mem_we_rd", mem_we, 0);
    if (v) begin
      chk("mem_addr", mem_addr, e);
      for (int i = 0; i < int'(delay); i++) begin
        chk("wait_n_stretch", wait_n, 0);
        chk("mem_rd_level", mem_rd, 1);
        cyc();
      end
      mem_ready = 1'b1;
      cyc();
      mem_ready = 1'b0;
      chk("mem_rd_done", mem_rd, 0);
      chk("wait_n_done", wait_n, 1);
      chk("mem_addr_hold", mem_addr, e);
    end else begin
      chk("wait_n_oor", wait_n, 1);
    end
    for (int i = 0; i < int'(hold); i++) begin
      cyc();
      chk("no_rerequest", mem_rd, 0);
      chk("wait_n_hold", wait_n, 1);
    end
    rd = 1'b0;
    cyc();
    SLTSL_n = 1'b1;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    reset_n = 1'b0; mapper = 3'd4; offset = 4'd0; rom_size = 25'h20000;
    addr = '0; d_from_cpu = '0; wr = 1'b0; rd = 1'b0; SLTSL_n = 1'b1; mem_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_sram", mem_sram, 0);
    chk("rst_wait_n", wait_n, 1);
    reset_n = 1'b1;
    cyc(); cyc();
    model_defaults();

    // SCC: write 0Fh to 9000h, read 8123h
    do_write('h9000, 'h0F);
    chk("scc_model", exp_addr('h8123), 'h1E123);
    do_read('h8123, 1, 0);

    // Long handshake with rd held afterwards
    do_read('hA000, 5, 2);

    // Bank write while a request is outstanding
    e0 = exp_addr('h8000);
    addr = 16'h8000; SLTSL_n = 1'b0; rd = 1'b1;
    cyc();
    addr = 16'h9000; d_from_cpu = 8'h21; wr = 1'b1;
    cyc();
    wr = 1'b0;
    chk("req_addr_stable", mem_addr, e0);
    chk("req_mem_rd", mem_rd, 1);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("req_done", mem_rd, 0);
    rd = 1'b0;
    cyc();
    SLTSL_n = 1'b1;
    model_write('h9000, 'h21);
    do_read('h8000, 0, 0);

    // Bank write visible to a read starting next cycle
    addr = 16'h9000; d_from_cpu = 8'h05; SLTSL_n = 1'b0; wr = 1'b1;
    cyc();
    model_write('h9000, 'h05);
    wr = 1'b0; addr = 16'h8010; rd = 1'b1;
    cyc();
    chk("b2b_mem_rd", mem_rd, 1);
    chk("b2b_mem_addr", mem_addr, exp_addr('h8010));
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0; rd = 1'b0;
    cyc();
    SLTSL_n = 1'b1;

    // Simultaneous rd and wr: write wins
    addr = 16'hB000; d_from_cpu = 8'h07; SLTSL_n = 1'b0; wr = 1'b1; rd = 1'b1;
    #1;
    chk("rdwr_wait_n", wait_n, 1);
    cyc();
    chk("rdwr_no_rd", mem_rd, 0);
    wr = 1'b0; rd = 1'b0;
    cyc();
    SLTSL_n = 1'b1;
    model_write('hB000, 'h07);
    do_read('hA123, 0, 0);

    // Out-of-range reads in a mapped mode
    do_read('hC000, 0, 0);
    do_read('h3FFF, 0, 0);

    // Reset during REQ
    do_write('h9000, 'h33);
    addr = 16'h8000; SLTSL_n = 1'b0; rd = 1'b1;
    cyc();
    chk("pre_reset_mem_rd", mem_rd, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_mem_rd", mem_rd, 0);
    chk("async_rst_wait_n", wait_n, 1);
    chk("async_rst_mem_addr", mem_addr, 0);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    reset_n = 1'b1;
    cyc();
    chk("post_rst_mem_rd", mem_rd, 0);
    chk("post_rst_wait_n", wait_n, 1);
    rd = 1'b0;
    cyc();
    SLTSL_n = 1'b1;
    model_defaults();
    do_read('h4000, 0, 0);
    do_read('h6000, 0, 0);
    do_read('h8000, 0, 0);
    do_read('hA000, 0, 0);

    // ASCII16: write 05h to 7000h, read A010h
    set_mapper(6);
    do_write('h7000, 'h05);
    chk("a16_model", exp_addr('hA010), 'h16010);
    do_read('hA010, 0, 0);

    // Konami: bank0 fixed
    set_mapper(3);
    do_write('h4000, 'h12);
    do_read('h4123, 0, 0);
    do_write('h6000, 'h09);
    do_read('h6001, 2, 0);

    // Nomapper with offset
    set_mapper(1);
    offset = 4'd4; rom_size = 25'h8000;
    chk("nom_model", exp_addr('h4001), 'h0001);
    do_read('h4001, 0, 0);
    do_read('hC000, 1, 0);

    // Randomized mix
    for (int it = 0; it < 60; it++) begin
      int unsigned op = $urandom_range(0, 9);
      if (op == 0) begin
        set_mapper($urandom_range(0, 7));
        rom_size = 25'(1 << $urandom_range(13, 21));
        offset   = 4'($urandom_range(0, 15));
      end else if (op <= 4) begin
        int unsigned d = $urandom_range(0, 255);
`ifdef CART_MAPPER_SRAM_EN
        d = d & 'h7F;
`endif
        do_write($urandom_range('h5000, 'hBFFF), d);
      end else begin
        do_read($urandom_range(0, 'hFFFF), $urandom_range(0, 3), $urandom_range(0, 1));
      end
    end

`ifdef CART_MAPPER_SRAM_EN
    set_mapper(5);
    rom_size = 25'h20000;
    do_write('h7000, 'h80);
    addr = 16'h8004; d_from_cpu = 8'h5A; SLTSL_n = 1'b0; wr = 1'b1;
    #1;
    chk("sram_wait_n", wait_n, 0);
    cyc();
    chk("sram_we", mem_we, 1);
    chk("sram_sel", mem_sram, 1);
    chk("sram_addr", mem_addr, 'h0004);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("sram_we_done", mem_we, 0);
    chk("sram_wait_done", wait_n, 1);
    wr = 1'b0;
    cyc();
    SLTSL_n = 1'b1;
    do_write('h7000, 'h03);
    do_read('h8004, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
